// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath: default vector length,
// command-word bit positions and the write-controller state type.
package vec_pkg;

  localparam int N_ELEMS = 1024;

  // One-hot positions inside the decoder's command word.
  localparam int CMD_WRITE = 6;
  localparam int CMD_DOT   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/vector_write_ctrl_if.sv
// Bundle between the command/UART side (master) and the vector write
// controller (slave), including the BRAM write port and a state debug tap.
interface vector_write_ctrl_if #(
  parameter int ADDR_W = 10
);
  import vec_pkg::*;

  // start is a level held by the master until write_done is seen.
  // rx_ready is a valid-only strobe with no back-pressure: a pulse seen in RECV is always consumed.
  logic              start;
  logic              bram_sel;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              bram_a_we;
  logic              bram_b_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_din;
  logic              busy;
  logic              write_done;
  logic              write_err;
  state_t            state;

  modport master (
    output start, bram_sel, rx_ready, rx_data,
    input  bram_a_we, bram_b_we, bram_addr, bram_din, busy, write_done, write_err, state
  );

  modport slave (
    input  start, bram_sel, rx_ready, rx_data,
    output bram_a_we, bram_b_we, bram_addr, bram_din, busy, write_done, write_err, state
  );

endinterface

// File: rtl/vector_write_ctrl.sv
// Streams N_ELEMS UART bytes into BRAM A or B, selected when start rises,
// with an inter-byte timeout and a release phase that waits for start to drop.
module vector_write_ctrl #(
  parameter int N_ELEMS     = vec_pkg::N_ELEMS,
  parameter int ADDR_W      = $clog2(N_ELEMS),
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  vector_write_ctrl_if.slave  bus
);
  import vec_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       rst_sync;
  logic             run;
  state_t           state;
  logic [CNT_W-1:0] count;
  logic [TMR_W-1:0] timer;
  logic             sel_q;

  // Assertion is immediate; release reaches the FSM two clocks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run       = rst_sync[1];
  assign bus.state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      count          <= '0;
      timer          <= '0;
      sel_q          <= 1'b0;
      bus.bram_a_we  <= 1'b0;
      bus.bram_b_we  <= 1'b0;
      bus.bram_addr  <= '0;
      bus.bram_din   <= '0;
      bus.busy       <= 1'b0;
      bus.write_done <= 1'b0;
      bus.write_err  <= 1'b0;
    end else if (!run) begin
      state          <= IDLE;
      count          <= '0;
      timer          <= '0;
      sel_q          <= 1'b0;
      bus.bram_a_we  <= 1'b0;
      bus.bram_b_we  <= 1'b0;
      bus.bram_addr  <= '0;
      bus.bram_din   <= '0;
      bus.busy       <= 1'b0;
      bus.write_done <= 1'b0;
      bus.write_err  <= 1'b0;
    end else begin
      bus.bram_a_we  <= 1'b0;
      bus.bram_b_we  <= 1'b0;
      bus.write_done <= 1'b0;
      bus.write_err  <= 1'b0;
      case (state)
        // rx_ready here is the command byte itself and is deliberately dropped.
        IDLE: begin
          if (bus.start) begin
            sel_q    <= bus.bram_sel;
            count    <= '0;
            timer    <= '0;
            bus.busy <= 1'b1;
            state    <= RECV;
          end
        end
        RECV: begin
          if (bus.rx_ready) begin
            bus.bram_addr <= count[ADDR_W-1:0];
            bus.bram_din  <= bus.rx_data;
            bus.bram_a_we <= ~sel_q;
            bus.bram_b_we <= sel_q;
            count         <= count + CNT_W'(1);
            timer         <= '0;
            if (count == CNT_W'(N_ELEMS - 1)) begin
              bus.write_done <= 1'b1;
              state          <= DONE;
            end
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            bus.write_done <= 1'b1;
            bus.write_err  <= 1'b1;
            state          <= DONE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= RELEASE;
        end
        // Wait for the decoder to drop start so a held level cannot retrigger.
        RELEASE: begin
          if (!bus.start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_write_ctrl.sv
// Bench for vector_write_ctrl with N_ELEMS=4 and TIMEOUT_CYC=50: directed
// scenarios with literal expectations plus randomized transfers against a cycle model.
module tb_vector_write_ctrl;

  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int TO  = 50;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cyc;
  bit   chk_en;

  vector_write_ctrl_if #(.ADDR_W(AW)) bus ();

  vector_write_ctrl #(.N_ELEMS(N), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the outputs must be after the latest edge.
  bit          m_a_we, m_b_we, m_busy, m_done, m_err;
  logic [AW-1:0] m_addr;
  logic [7:0]  m_din;
  bit          m_recv, m_done_cycle, m_release, m_sel;
  int          written, quiet, sync_cnt;

  // Observation log for the directed scenarios.
  bit          log_b[$];
  int          log_addr[$];
  logic [7:0]  log_data[$];
  int          log_cyc[$];
  logic [7:0]  exp_q[$];
  int          done_cnt, err_cnt, done_cyc;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    bus.rx_ready = 1'b1;
    bus.rx_data  = d;
    tick(1);
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'($urandom);
    tick(gap);
  endtask

  task automatic clear_log();
    log_b.delete(); log_addr.delete(); log_data.delete(); log_cyc.delete();
    exp_q.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1;
  endtask

  task automatic check_log(input int n, input bit sel, input int err);
    check("n_writes", log_data.size(), n);
    for (int i = 0; i < log_data.size() && i < n; i++) begin
      check("wr_sel", int'(log_b[i]), int'(sel));
      check("wr_addr", log_addr[i], i);
      check("wr_data", int'(log_data[i]), int'(exp_q[i]));
    end
    check("done_cnt", done_cnt, 1);
    check("err_cnt", err_cnt, err);
  endtask

  task automatic model_reset();
    m_a_we = 0; m_b_we = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_addr = '0; m_din = '0;
    m_recv = 0; m_done_cycle = 0; m_release = 0; m_sel = 0;
    written = 0; quiet = 0; sync_cnt = 0;
  endtask

  task automatic model_finish(input bit err);
    m_recv = 0; m_done_cycle = 1; m_done = 1; m_err = err;
  endtask

  task automatic model_step();
    m_a_we = 0; m_b_we = 0; m_done = 0; m_err = 0;
    if (sync_cnt < 2) sync_cnt++;
    else if (m_done_cycle) begin
      m_done_cycle = 0;
      m_release    = 1;
    end else if (m_release) begin
      if (!bus.start) m_release = 0;
    end else if (m_recv) begin
      if (bus.rx_ready) begin
        m_addr = AW'(written);
        m_din  = bus.rx_data;
        if (m_sel) m_b_we = 1; else m_a_we = 1;
        written++;
        quiet = 0;
        if (written == N) model_finish(0);
      end else begin
        quiet++;
        if (quiet == TO) model_finish(1);
      end
    end else if (bus.start) begin
      m_recv = 1; m_sel = bus.bram_sel; written = 0; quiet = 0;
    end
    m_busy = m_recv || m_done_cycle;
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        cyc++;
        model_step();
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("a_we", int'(bus.bram_a_we), int'(m_a_we));
        check("b_we", int'(bus.bram_b_we), int'(m_b_we));
        check("addr", int'(bus.bram_addr), int'(m_addr));
        check("din", int'(bus.bram_din), int'(m_din));
        check("busy", int'(bus.busy), int'(m_busy));
        check("done", int'(bus.write_done), int'(m_done));
        check("err", int'(bus.write_err), int'(m_err));
        if (bus.bram_a_we || bus.bram_b_we) begin
          log_b.push_back(bus.bram_b_we);
          log_addr.push_back(int'(bus.bram_addr));
          log_data.push_back(bus.bram_din);
          log_cyc.push_back(cyc);
        end
        if (bus.write_done) begin
          done_cnt++;
          done_cyc = cyc;
          if (bus.write_err) err_cnt++;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_we"}, int'(bus.bram_a_we), 0);
    check({tag, "_b_we"}, int'(bus.bram_b_we), 0);
    check({tag, "_addr"}, int'(bus.bram_addr), 0);
    check({tag, "_din"}, int'(bus.bram_din), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.write_done), 0);
    check({tag, "_err"}, int'(bus.write_err), 0);
    check({tag, "_state"}, int'(bus.state), 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; chk_en = 0;
    model_reset();
    clear_log();
    rst = 1'b1;
    bus.start = 1'b0; bus.bram_sel = 1'b0; bus.rx_ready = 1'b0; bus.rx_data = 8'h00;
    fork
      model_loop();
      compare_loop();
    join_none
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_init");
    chk_en = 1;
    tick(2);
    rst = 1'b1;
    tick(4);

    // Spaced bytes into BRAM A.
    clear_log();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.bram_sel = 1'b0; bus.start = 1'b1;
    tick(1);
    foreach (exp_q[i]) send_byte(exp_q[i], 9);
    check_log(4, 1'b0, 0);
    if (log_cyc.size() == 4) check("done_with_last", done_cyc, log_cyc[3]);
    bus.start = 1'b0;
    tick(3);

    // BRAM B selected, select toggled during the transfer.
    clear_log();
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    bus.bram_sel = 1'b1; bus.start = 1'b1;
    tick(1);
    foreach (exp_q[i]) begin
      bus.bram_sel = ~bus.bram_sel;
      send_byte(exp_q[i], $urandom_range(0, 5));
    end
    tick(3);
    check_log(4, 1'b1, 0);
    bus.start = 1'b0;
    tick(3);

    // Back-to-back bytes.
    clear_log();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    bus.bram_sel = 1'b0; bus.start = 1'b1;
    tick(1);
    foreach (exp_q[i]) send_byte(exp_q[i], 0);
    tick(3);
    check_log(4, 1'b0, 0);
    for (int i = 1; i < log_cyc.size(); i++) check("consecutive", log_cyc[i] - log_cyc[0], i);
    bus.start = 1'b0;
    tick(3);

    // Timeout after two bytes.
    clear_log();
    exp_q = '{8'h5A, 8'hC3};
    bus.bram_sel = 1'b1; bus.start = 1'b1;
    tick(1);
    send_byte(exp_q[0], 2);
    send_byte(exp_q[1], 0);
    tick(60);
    check_log(2, 1'b1, 1);
    if (log_cyc.size() == 2) check("timeout_gap", done_cyc - log_cyc[1], TO);
    bus.start = 1'b0;
    tick(3);

    // Command byte on the start edge, stray byte in release, held start.
    clear_log();
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    bus.bram_sel = 1'b0; bus.start = 1'b1;
    bus.rx_ready = 1'b1; bus.rx_data = 8'hEE;
    tick(1);
    bus.rx_ready = 1'b0;
    foreach (exp_q[i]) send_byte(exp_q[i], 2);
    send_byte(8'hDD, 3);
    tick(10);
    check_log(4, 1'b0, 0);
    check("held_start_busy", int'(bus.busy), 0);
    bus.start = 1'b0;
    tick(2);
    clear_log();
    exp_q = '{8'h71, 8'h72, 8'h73, 8'h74};
    bus.start = 1'b1;
    tick(1);
    foreach (exp_q[i]) send_byte(exp_q[i], 1);
    tick(3);
    check_log(4, 1'b0, 0);
    bus.start = 1'b0;
    tick(3);

    // Reset mid-transfer, then a clean transfer from address 0.
    clear_log();
    bus.bram_sel = 1'b1; bus.start = 1'b1;
    tick(1);
    send_byte(8'h9A, 3);
    send_byte(8'h9B, 3);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    bus.start = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(4);
    check("rst_no_done", done_cnt, 0);
    clear_log();
    exp_q = '{8'h55, 8'h56, 8'h57, 8'h58};
    bus.bram_sel = 1'b0; bus.start = 1'b1;
    tick(1);
    foreach (exp_q[i]) send_byte(exp_q[i], $urandom_range(0, 3));
    tick(3);
    check_log(4, 1'b0, 0);
    bus.start = 1'b0;
    tick(3);

    // Randomized transfers, some cut short to hit the timeout.
    for (int t = 0; t < 8; t++) begin
      int nb;
      nb = (t % 3 == 2) ? $urandom_range(0, 3) : N;
      bus.bram_sel = 1'($urandom_range(0, 1));
      bus.start = 1'b1;
      bus.rx_ready = 1'($urandom_range(0, 1));
      tick(1);
      bus.rx_ready = 1'b0;
      for (int i = 0; i < nb; i++) begin
        bus.bram_sel = 1'($urandom_range(0, 1));
        send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 4));
      end
      tick(nb < N ? 60 : 3);
      send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 2));
      bus.start = 1'b0;
      tick($urandom_range(1, 3));
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_write_ctrl.md
VECTOR_WRITE_CTRL -- requirements
Module: vector_write_ctrl

Interface
REQ-001 Parameter N_ELEMS, default 1024: number of bytes per vector write transfer.
REQ-002 Parameter ADDR_W, default $clog2(N_ELEMS): BRAM address width.
REQ-003 Parameter TIMEOUT_CYC, default 1_000_000: maximum idle cycles between received bytes before abort.
REQ-004 clk  input  1  single clock for the whole block; all logic on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  write-enable level from the command decoder (command_out[6]); held high until write_done is seen.
REQ-007 bram_sel  input  1  target vector while start is high: 0 selects BRAM A, 1 selects BRAM B.
REQ-008 rx_ready  input  1  one-cycle pulse, UART byte valid.
REQ-009 rx_data  input  8  UART byte, valid when rx_ready=1.
REQ-010 bram_a_we  output  1  write strobe for BRAM A.
REQ-011 bram_b_we  output  1  write strobe for BRAM B.
REQ-012 bram_addr  output  ADDR_W  write address shared by both BRAMs.
REQ-013 bram_din  output  8  write data shared by both BRAMs.
REQ-014 busy  output  1  high while a transfer is in progress.
REQ-015 write_done  output  1  one-cycle pulse ending a transfer (normal or aborted).
REQ-016 write_err  output  1  one-cycle pulse, coincident with write_done, when a transfer was aborted by timeout.

Function
REQ-017 States: IDLE, RECV, DONE, RELEASE.
REQ-018 IDLE: on start=1, latch bram_sel into sel_q, clear byte count and timer, go to RECV. rx_ready in IDLE, including the cycle start rises, is ignored (it is the command byte).
REQ-019 RECV: on rx_ready=1 at cycle t, at t+1 bram_addr=count, bram_din=rx_data(t), and exactly one strobe is high for one cycle (bram_a_we if sel_q=0, else bram_b_we). count increments and the timer clears.
REQ-020 Back-to-back rx_ready on consecutive cycles is accepted without loss: one write per pulse.
REQ-021 When the byte with count=N_ELEMS-1 is accepted at t, go to DONE. Its strobe occurs at t+1 and write_done pulses at t+1.
REQ-022 rx_ready in DONE or RELEASE is ignored; no strobe is produced.
REQ-023 RECV timeout: the timer counts cycles without rx_ready. When it reaches TIMEOUT_CYC, go to DONE with write_err=1; already written bytes stay in the BRAM.
REQ-024 DONE lasts one cycle and drives the write_done (and any write_err) pulse, then goes to RELEASE.
REQ-025 RELEASE: stay until start=0, then go to IDLE, so a lingering start level never retriggers.
REQ-026 busy=1 in RECV and DONE; busy=0 in IDLE and RELEASE.
REQ-027 Changes on bram_sel or start after the latch in IDLE are ignored until the block returns to IDLE.
REQ-028 count is ADDR_W+1 bits wide and does not wrap. bram_addr always lies within 0..N_ELEMS-1.
REQ-029 bram_addr and bram_din hold their last value when no strobe is active.

Reset
REQ-030 While rst=0: state=IDLE, count=0, timer=0, sel_q=0, and all outputs are 0, independent of clk.
REQ-031 Reset mid-transfer aborts immediately: no further strobes and no write_done. After rst=1, a new start begins at address 0.
REQ-032 Reset deassertion is synchronised to clk before it is used by the state register.

Structure
REQ-033 Shared package vec_pkg holds N_ELEMS, the command one-hot bit indices (WRITE=6 ... DOT=0) and the state enum type.
REQ-034 Single module, no sub-modules. The timer and count are local counters.

Verification
REQ-035 N_ELEMS=4, bram_sel=0, start high, bytes 0x11,0x22,0x33,0x44 spaced 10 cycles apart -> bram_a_we at addresses 0..3 with those data, bram_b_we never high, write_done pulses once with the last strobe, write_err=0.
REQ-036 bram_sel=1 at start, then bram_sel toggled mid-transfer, bytes 0xA0..0xA3 -> only bram_b_we strobes, at addresses 0..3.
REQ-037 rx_ready pulses on 4 consecutive cycles with 0x01..0x04 -> 4 strobes on consecutive cycles, addresses 0..3, no byte dropped.
REQ-038 TIMEOUT_CYC=50, 2 bytes then silence -> after 50 idle cycles write_done=1 and write_err=1, exactly 2 strobes seen.
REQ-039 rx_ready coincident with the start rise, plus rx_ready in RELEASE with start still high -> neither byte is written, and no second transfer starts until start drops and rises again.
REQ-040 rst=0 asserted after byte 2 of 4 -> outputs 0 asynchronously, no write_done. A following transfer of 0x55..0x58 writes to addresses 0..3.
